// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/hazard unit: producer kinds, tracker entry, select encoding.
package hazard_pkg;

  // Tracker rd field is sized for the widest supported register index; narrower indices zero-extend.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_LINK = 2'd2
  } kind_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    kind_e               kind;
  } trk_entry_t;

  localparam int SEL_REGFILE = 0;

  function automatic int sel_code(input int stage, input kind_e kind);
    return (kind == KIND_LINK) ? 2 * stage : 2 * stage - 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One source operand against every tracked producer: youngest match picks the bypass select,
// and a match on the EX-bound load raises the load-use flag.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_ENT = 2,
  parameter int SEL_W   = 3
) (
  input  logic [REG_AW-1:0]           rs,
  input  logic [NUM_ENT-1:0]          ent_valid,
  input  logic [NUM_ENT-1:0]          ent_we,
  input  logic [NUM_ENT*RD_MAX_W-1:0] ent_rd,
  input  logic [NUM_ENT*2-1:0]        ent_kind,
  output logic [SEL_W-1:0]            sel,
  output logic                        load_use
);

  // Oldest first, so the youngest match overwrites and wins.
  always_comb begin
    sel      = SEL_W'(SEL_REGFILE);
    load_use = 1'b0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_we[i] &&
          (ent_rd[i*RD_MAX_W +: RD_MAX_W] != '0) &&
          (ent_rd[i*RD_MAX_W +: RD_MAX_W] == RD_MAX_W'(rs))) begin
        sel      = SEL_W'(sel_code(i + 1, kind_e'(ent_kind[i*2 +: 2])));
        load_use = (i == 0) && (kind_e'(ent_kind[i*2 +: 2]) == KIND_LOAD);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Registered forwarding-select and load-use stall controller between decode and EX.
// Optional HAZ_PERF_EN adds saturating stall/flush cycle counters.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int REG_AW  = 5,
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 3,
  localparam int SEL_W   = $clog2(2 * (DEPTH - 1) + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_we_i,
  input  logic [1:0]                id_kind_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o,
`ifdef HAZAD_PERF_EN_UNUSED
`endif
`ifdef HAZ_PERF_EN
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o,
`endif
  output logic                      ex_valid_o
);

  // The WB-bound producer is not stored: regfile write-through already covers it.
  localparam int NUM_ENT = DEPTH - 1;

  trk_entry_t                   trk_reg [NUM_ENT];
  logic [NUM_ENT-1:0]           ent_valid;
  logic [NUM_ENT-1:0]           ent_we;
  logic [NUM_ENT*RD_MAX_W-1:0]  ent_rd;
  logic [NUM_ENT*2-1:0]         ent_kind;
  logic [NUM_SRC*SEL_W-1:0]     sel_next;
  logic [NUM_SRC-1:0]           load_use;
  logic [NUM_SRC*SEL_W-1:0]     sel_reg;
  logic                         valid_reg;
  logic                         bubble;
  trk_entry_t                   id_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENT; gi++) begin : g_flat
      assign ent_valid[gi]                     = trk_reg[gi].valid;
      assign ent_we[gi]                        = trk_reg[gi].we;
      assign ent_rd[gi*RD_MAX_W +: RD_MAX_W]   = trk_reg[gi].rd;
      assign ent_kind[gi*2 +: 2]               = trk_reg[gi].kind;
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_match #(
        .REG_AW  (REG_AW),
        .NUM_ENT (NUM_ENT),
        .SEL_W   (SEL_W)
      ) u_match (
        .rs        (id_rs_i[gi*REG_AW +: REG_AW]),
        .ent_valid (ent_valid),
        .ent_we    (ent_we),
        .ent_rd    (ent_rd),
        .ent_kind  (ent_kind),
        .sel       (sel_next[gi*SEL_W +: SEL_W]),
        .load_use  (load_use[gi])
      );
    end
  endgenerate

  assign stall_o = (|load_use) & id_valid_i & ~flush_i & ~hold_i;
  assign bubble  = stall_o | flush_i | ~id_valid_i;

  always_comb begin
    id_entry       = '0;
    id_entry.valid = 1'b1;
    id_entry.rd    = RD_MAX_W'(id_rd_i);
    id_entry.we    = id_we_i;
    id_entry.kind  = kind_e'(id_kind_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) trk_reg[i] <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (!hold_i) begin
      for (int i = 1; i < NUM_ENT; i++) trk_reg[i] <= trk_reg[i-1];
      trk_reg[0] <= bubble ? '0 : id_entry;
      sel_reg    <= bubble ? '0 : sel_next;
      valid_reg  <= ~bubble;
    end
  end

  assign ex_fwd_sel_o = sel_reg;
  assign ex_valid_o   = valid_reg;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_o && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush_i && !hold_i && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: short instruction sequences with hand-computed selects.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int SEL_W   = 3;
  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_LINK = 2'd2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      hold_i;
  logic                      flush_i;
  logic                      id_valid_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0]         id_rd_i;
  logic                      id_we_i;
  logic [1:0]                id_kind_i;
  logic                      stall_o;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o;
  logic                      ex_valid_o;
`ifdef HAZ_PERF_EN
  logic [31:0]               stall_cnt_o;
  logic [31:0]               flush_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rd_i      (id_rd_i),
    .id_we_i      (id_we_i),
    .id_kind_i    (id_kind_i),
    .stall_o      (stall_o),
    .ex_fwd_sel_o (ex_fwd_sel_o),
`ifdef HAZ_PERF_EN
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o),
`endif
    .ex_valid_o   (ex_valid_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    tests_run++;
    if (obs !== exp_val) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [1:0] kind);
    id_valid_i = v;
    id_rs_i    = {rs2, rs1};
    id_rd_i    = rd;
    id_we_i    = we;
    id_kind_i  = kind;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, K_ALU);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] sel(input int j);
    logic [NUM_SRC*SEL_W-1:0] v;
    v = ex_fwd_sel_o;
    return 32'(v[j*SEL_W +: SEL_W]);
  endfunction

  initial begin
    rst_n   = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, K_ALU);
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("reset_valid", 32'(ex_valid_o), 0);
    check("reset_sel",   32'(ex_fwd_sel_o), 0);
    check("reset_stall", 32'(stall_o), 0);

    // 1: add x5 ; add x6,x5,x5 -> MEM result (1) on both operands
    tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, K_ALU);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, K_ALU);
    settle();
    check("t1_stall", 32'(stall_o), 0);
    tick();
    settle();
    check("t1_sel0",  sel(0), 1);
    check("t1_sel1",  sel(1), 1);
    check("t1_valid", 32'(ex_valid_o), 1);
    drain();

    // 2: lw x7 ; add x8,x7,x0 -> one stall, bubble, then WB result (3)
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, K_LOAD);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, K_ALU);
    settle();
    check("t2_stall", 32'(stall_o), 1);
    tick();
    settle();
    check("t2_bubble_valid", 32'(ex_valid_o), 0);
    check("t2_bubble_sel",   32'(ex_fwd_sel_o), 0);
    check("t2_stall_drop",   32'(stall_o), 0);
    tick();
    settle();
    check("t2_sel0",  sel(0), 3);
    check("t2_sel1",  sel(1), 0);
    check("t2_valid", 32'(ex_valid_o), 1);
    drain();

    // 3a: jal x1 ; nop ; add x2,x1,x1 -> WB link (4)
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, K_LINK);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, K_ALU);
    tick();
    set_id(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, K_ALU);
    tick();
    settle();
    check("t3_wb_link0", sel(0), 4);
    check("t3_wb_link1", sel(1), 4);
    drain();
    // 3b: jal x1 ; add x2,x1,x1 -> MEM link (2)
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, K_LINK);
    tick();
    set_id(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, K_ALU);
    settle();
    check("t3_link_stall", 32'(stall_o), 0);
    tick();
    settle();
    check("t3_mem_link0", sel(0), 2);
    check("t3_mem_link1", sel(1), 2);
    drain();

    // 4: add x5 ; add x5 ; sub x9,x5,x5 -> youngest (1)
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, K_ALU);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, K_ALU);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, K_ALU);
    tick();
    settle();
    check("t4_young0", sel(0), 1);
    check("t4_young1", sel(1), 1);
    drain();
    // rd=x0 producer never forwards
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, K_ALU);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, K_ALU);
    tick();
    settle();
    check("t4_x0_sel", 32'(ex_fwd_sel_o), 0);
    drain();
    // non-writing producer never forwards
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, K_ALU);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd3, 1'b1, K_ALU);
    tick();
    settle();
    check("t4_nowe_sel", 32'(ex_fwd_sel_o), 0);
    drain();

    // 5a: lw x7 + dependent with flush -> no stall, bubble
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, K_LOAD);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, K_ALU);
    flush_i = 1'b1;
    settle();
    check("t5_flush_stall", 32'(stall_o), 0);
    tick();
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, K_ALU);
    settle();
    check("t5_flush_valid", 32'(ex_valid_o), 0);
    check("t5_flush_sel",   32'(ex_fwd_sel_o), 0);
    drain();
    // 5b: add x5 ; lw x7,(x5) ; dependent add held for 3 cycles
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, K_ALU);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, K_LOAD);
    tick();
    set_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, K_ALU);
    hold_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("t5_hold%0d_sel0", c),  sel(0), 1);
      check($sformatf("t5_hold%0d_sel1", c),  sel(1), 0);
      check($sformatf("t5_hold%0d_valid", c), 32'(ex_valid_o), 1);
      check($sformatf("t5_hold%0d_stall", c), 32'(stall_o), 0);
      tick();
    end
    hold_i = 1'b0;
    settle();
    check("t5_release_stall", 32'(stall_o), 1);
    tick();
    tick();
    settle();
    check("t5_after_sel0", sel(0), 3);
    check("t5_after_sel1", sel(1), 3);
    drain();

    // 6: reset while stalled
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, K_LOAD);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, K_ALU);
    settle();
    check("t6_pre_stall", 32'(stall_o), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("t6_stall", 32'(stall_o), 0);
    check("t6_sel",   32'(ex_fwd_sel_o), 0);
    check("t6_valid", 32'(ex_valid_o), 0);
`ifdef HAZ_PERF_EN
    check("t6_stall_cnt", stall_cnt_o, 0);
    check("t6_flush_cnt", flush_cnt_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
